// File: rtl/pl_perf_counter_unit.sv
// pl_perf_counter_unit
//   Run-statistics counters for the pipelined CPU: cycles, stalls, resolved
//   branch predictions and mispredictions. On hlt the unit keeps counting
//   events for DRAIN_CYCLES edges so in-flight branches still resolve, then
//   freezes until clr_i. A req/ack debug port reads one counter at a time.
//   Optional build macro: PERF_SATURATE_EN (counters stick at all-ones
//   instead of wrapping).
module pl_perf_counter_unit #(
   parameter int WIDTH        = 32,
   parameter int DRAIN_CYCLES = 4
) (
   input  logic             input_clk,
   input  logic             rst,
   input  logic             hlt_i,
   input  logic             stall_i,
   input  logic             branch_valid_i,
   input  logic             branch_miss_i,
   input  logic             clr_i,
   input  logic             rd_req_i,
   input  logic [1:0]       rd_addr_i,
   output logic             rd_ack_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic [WIDTH-1:0] cycles_consumed,
   output logic [WIDTH-1:0] StallCount,
   output logic [WIDTH-1:0] BranchPredictionCount,
   output logic [WIDTH-1:0] BranchPredictionMissCount,
   output logic             halted_o
);

   localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DW-1:0] DRAIN_INIT = (DRAIN_CYCLES > 0) ? DW'(DRAIN_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   drain_q, drain_d;
   logic            halted_q, halted_d;
   logic            rd_ack_q, rd_ack_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   // Counter slots: 0 cycles, 1 stalls, 2 branches, 3 misses (same as rd_addr_i).
   logic [WIDTH-1:0] cnt_q [4];
   logic [WIDTH-1:0] cnt_d [4];
   logic [3:0]       inc;

   // One-step counter advance; overflow policy chosen at build time.
   function automatic logic [WIDTH-1:0] bump(input logic [WIDTH-1:0] v, input logic en);
`ifdef PERF_SATURATE_EN
      if (en && (v != '1)) return v + WIDTH'(1);
      else                 return v;
`else
      if (en) return v + WIDTH'(1);
      else    return v;
`endif
   endfunction

   // Next-state logic: RUN -> DRAIN -> FROZEN, clr_i forces RUN from anywhere.
   always_comb begin
      state_d = state_q;
      drain_d = drain_q;
      if (clr_i) begin
         state_d = ST_RUN;
         drain_d = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (hlt_i) begin
                  if (DRAIN_CYCLES == 0) begin
                     state_d = ST_FROZEN;
                  end else begin
                     state_d = ST_DRAIN;
                     drain_d = DRAIN_INIT;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_q == '0) state_d = ST_FROZEN;
               else               drain_d = drain_q - DW'(1);
            end
            ST_FROZEN: begin
               state_d = ST_FROZEN;
            end
            default: begin
               state_d = ST_RUN;
               drain_d = '0;
            end
         endcase
      end
      halted_d = (state_d == ST_FROZEN);
   end

   // State, drain countdown and halted flag registers.
   always_ff @(posedge input_clk) begin
      if (!rst) begin
         state_q  <= ST_RUN;
         drain_q  <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         drain_q  <= drain_d;
         halted_q <= halted_d;
      end
   end

   // Per-counter increment enables; the hlt cycle itself is not a counted cycle,
   // and DRAIN keeps event counters live while the cycle count is frozen.
   always_comb begin
      inc = 4'b0000;
      case (state_q)
         ST_RUN:   inc = {branch_valid_i & branch_miss_i, branch_valid_i, stall_i, ~hlt_i};
         ST_DRAIN: inc = {branch_valid_i & branch_miss_i, branch_valid_i, stall_i, 1'b0};
         default:  inc = 4'b0000;
      endcase
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
         // Clear wins over any event seen in the same cycle.
         always_comb begin
            cnt_d[gi] = clr_i ? '0 : bump(cnt_q[gi], inc[gi]);
         end

         // Counter register.
         always_ff @(posedge input_clk) begin
            if (!rst) cnt_q[gi] <= '0;
            else      cnt_q[gi] <= cnt_d[gi];
         end
      end
   endgenerate

   // Debug read: capture the pre-update counter value, ack for one cycle; a held
   // request therefore acks every other cycle. Unaffected by clr_i.
   always_comb begin
      rd_ack_d  = 1'b0;
      rd_data_d = rd_data_q;
      if (rd_req_i && !rd_ack_q) begin
         rd_ack_d  = 1'b1;
         rd_data_d = cnt_q[rd_addr_i];
      end
   end

   // Read port registers.
   always_ff @(posedge input_clk) begin
      if (!rst) begin
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         rd_ack_q  <= rd_ack_d;
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_ack_o                  = rd_ack_q;
   assign rd_data_o                 = rd_data_q;
   assign halted_o                  = halted_q;
   assign cycles_consumed           = cnt_q[0];
   assign StallCount                = cnt_q[1];
   assign BranchPredictionCount     = cnt_q[2];
   assign BranchPredictionMissCount = cnt_q[3];

endmodule
